// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundles the controller's status inputs, its control outputs and the
//   data-memory request/ready handshake into one connection.
//
//   master : the controller (multicycle_control). It reads run, instr,
//            alu_zero and mem_ready, and drives every control output.
//   slave  : the datapath / memory side. It drives the status inputs and
//            reads the controls.
//
//   Signals
//     run          level enable, sampled in IDLE and at instruction boundaries
//     instr        IR contents, valid from DECODE onwards
//     alu_zero     ALU zero flag (used in BRANCH)
//     mem_ready    memory completes the current access this cycle
//     mem_req      memory access request
//     mem_we       1 = write (store), 0 = read
//     ir_write     IR load enable (fetch)
//     pc_write     PC update enable
//     pc_src       0 = ALU result, 1 = branch target register
//     reg_write    regfile write enable
//     result_src   0 = ALU result, 1 = memory read data
//     alu_src_b    00 = rs2, 01 = extended immediate, 10 = constant 4
//     alu_ctrl     000 = add, 001 = sub
//     imm_sel      00 = I, 01 = S, 10 = B immediate layout
//     ImmSrc       1 = sign-extend immediate, 0 = zero-extend
//     illegal      sticky unsupported-instruction flag
//     instr_count  retired-instruction count
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int WIDTH = 32
);
    logic             run;
    logic [WIDTH-1:0] instr;
    logic             alu_zero;
    logic             mem_ready;

    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic             result_src;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       imm_sel;
    logic             ImmSrc;
    logic             illegal;
    logic [WIDTH-1:0] instr_count;

    modport master (
        input  run, instr, alu_zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_b, alu_ctrl, imm_sel, ImmSrc, illegal,
               instr_count
    );

    modport slave (
        output run, instr, alu_zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               result_src, alu_src_b, alu_ctrl, imm_sel, ImmSrc, illegal,
               instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore FSM sequencing a multi-cycle RV32 datapath through fetch, decode,
//   execute, memory and writeback for ADDI, ADD, BNE, LBU and SB. Any other
//   encoding parks the controller in a sticky TRAP state until reset.
//   A retired-instruction counter advances once per completed instruction and
//   wraps silently.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset (state -> IDLE, count -> 0)
//     bus     multicycle_control_if.master: status inputs, control outputs,
//             memory handshake and retire count (see the interface file)
//
//   All control outputs are decoded from the state register (plus the opcode
//   in MEM_ADDR and alu_zero in BRANCH); none depends on mem_ready. Because
//   of that, ir_write/pc_write are held for every FETCH cycle: the datapath
//   qualifies the IR and PC loads with mem_ready so only the completing
//   fetch cycle actually loads them. Since the state register resets
//   asynchronously, every output (mem_req included) drops as soon as rst_n
//   falls.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_EXEC_R   = 4'd4;
    localparam logic [3:0] S_ALU_WB   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [WIDTH-1:0] r_instr_count;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_is_store;
    logic [3:0]       w_decoded;
    logic [3:0]       w_boundary;
    logic             w_retire;
    logic             w_unused_instr;

    assign w_opcode   = bus.instr[6:0];
    assign w_funct3   = bus.instr[14:12];
    assign w_funct7   = bus.instr[31:25];
    assign w_is_store = (w_opcode == OP_STORE);

    // Register and immediate fields are consumed by the datapath, not here.
    assign w_unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};

    // Instruction boundary: run is only honoured between instructions, so an
    // in-flight instruction always finishes before the FSM idles.
    assign w_boundary = bus.run ? S_FETCH : S_IDLE;

    // Opcode/funct decode used on the DECODE -> execute transition.
    always_comb begin
        w_decoded = S_TRAP;
        case (w_opcode)
            OP_IMM:    if (w_funct3 == 3'b000)                          w_decoded = S_EXEC_I;
            OP_REG:    if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) w_decoded = S_EXEC_R;
            OP_LOAD:   if (w_funct3 == 3'b100)                          w_decoded = S_MEM_ADDR;
            OP_STORE:  if (w_funct3 == 3'b000)                          w_decoded = S_MEM_ADDR;
            OP_BRANCH: if (w_funct3 == 3'b001)                          w_decoded = S_BRANCH;
            default:                                                    w_decoded = S_TRAP;
        endcase
    end

    // Next-state logic. mem_ready only matters in the three request states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.run)       w_next = S_FETCH;
            S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE:                      w_next = w_decoded;
            S_EXEC_I:                      w_next = S_ALU_WB;
            S_EXEC_R:                      w_next = S_ALU_WB;
            S_ALU_WB:                      w_next = w_boundary;
            S_MEM_ADDR:                    w_next = w_is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:                      w_next = w_boundary;
            S_MEM_WR:   if (bus.mem_ready) w_next = w_boundary;
            S_BRANCH:                      w_next = w_boundary;
            S_TRAP:                        w_next = S_TRAP;
            default:                       w_next = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    assign w_retire = (r_state == S_ALU_WB) ||
                      (r_state == S_MEM_WB) ||
                      (r_state == S_BRANCH) ||
                      ((r_state == S_MEM_WR) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retire counter; wraps from all-ones to zero with no flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign bus.instr_count = r_instr_count;

    // Moore output decode.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_ctrl   = 3'b000;
        bus.imm_sel    = 2'b00;
        bus.ImmSrc     = 1'b0;
        bus.illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Read at PC while the ALU forms PC+4 for the PC update.
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Speculatively compute PC+B-imm as the branch target.
                bus.alu_src_b = 2'b01;
                bus.imm_sel   = 2'b10;
                bus.ImmSrc    = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_b = 2'b01;
                bus.imm_sel   = 2'b00;
                bus.ImmSrc    = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_b = 2'b00;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.alu_src_b = 2'b01;
                bus.ImmSrc    = 1'b1;
                bus.imm_sel   = w_is_store ? 2'b01 : 2'b00;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2; take the branch target when they differ.
                bus.alu_src_b = 2'b00;
                bus.alu_ctrl  = 3'b001;
                bus.pc_src    = 1'b1;
                bus.pc_write  = ~bus.alu_zero;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
            end
            default: begin
                bus.illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    localparam int WIDTH = 32;

    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LBU  = 32'h00014083;
    localparam logic [31:0] I_SB   = 32'h00110023;
    localparam logic [31:0] I_BNE  = 32'h00209463;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if #(.WIDTH(WIDTH)) bus ();

    multicycle_control #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    logic [31:0] model_cnt;
    logic [31:0] last_cnt;

    // results captured by run_one
    int         lat, n_rw, n_we, n_req;
    logic       pcw_last, pcs_last, rw_last, hold_bad, after_req;
    logic [1:0] imm2, imm3;
    logic       src2, src3;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        zero;
        int          lat;
        int          rw;
        int          we;
        int          req;
        logic        pcw;
        logic        pcs;
        logic [1:0]  imm3;
        logic        src3;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.reg_write, bus.result_src, bus.alu_src_b, bus.alu_ctrl,
                bus.imm_sel, bus.ImmSrc, bus.illegal};
    endfunction

    // Advance to the next falling edge and retire any scoreboard entry whose
    // count change the DUT has just produced.
    task automatic tick();
        @(negedge clk);
        if (bus.instr_count !== last_cnt) begin
            if (sb_q.size() == 0) chk("sb_unexpected_retire", bus.instr_count, last_cnt);
            else                  chk("sb_count", bus.instr_count, sb_q.pop_front());
            last_cnt = bus.instr_count;
        end
    endtask

    // Run one instruction from IDLE with run pulsed for one cycle.
    // tie=1 holds mem_ready high; otherwise each request sees ready on its
    // (delay+1)-th cycle.
    task automatic run_one(input logic [31:0] ins, input logic zero, input bit tie,
                           input int delay, input bit retires);
        logic [31:0] c0;
        int          req_run;
        logic        prev_req, prev_we, prev_rdy;
        logic [1:0]  prev_bsel;
        c0 = bus.instr_count;
        lat = -1; n_rw = 0; n_we = 0; n_req = 0;
        pcw_last = 0; pcs_last = 0; rw_last = 0; hold_bad = 0; after_req = 1'bx;
        imm2 = 2'bxx; imm3 = 2'bxx; src2 = 1'bx; src3 = 1'bx;
        req_run = 0; prev_req = 0; prev_we = 0; prev_rdy = 0; prev_bsel = 2'b00;
        bus.instr = ins;
        bus.alu_zero = zero;
        bus.mem_ready = tie;
        bus.run = 1'b1;
        if (retires) begin
            model_cnt = model_cnt + 1;
            sb_q.push_back(model_cnt);
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc == 1) bus.run = 1'b0;
            if (bus.instr_count !== c0) begin
                lat = cyc - 1;
                after_req = bus.mem_req;
                break;
            end
            if (prev_req && !prev_rdy &&
                (bus.mem_req !== 1'b1 || bus.mem_we !== prev_we || bus.alu_src_b !== prev_bsel))
                hold_bad = 1;
            n_rw  += int'(bus.reg_write);
            n_we  += int'(bus.mem_we);
            n_req += int'(bus.mem_req);
            pcw_last = bus.pc_write;
            pcs_last = bus.pc_src;
            rw_last  = bus.reg_write;
            if (cyc == 2) begin imm2 = bus.imm_sel; src2 = bus.ImmSrc; end
            if (cyc == 3) begin imm3 = bus.imm_sel; src3 = bus.ImmSrc; end
            prev_req = bus.mem_req; prev_we = bus.mem_we; prev_bsel = bus.alu_src_b;
            if (!tie) begin
                req_run = bus.mem_req ? req_run + 1 : 0;
                bus.mem_ready = bus.mem_req && (req_run > delay);
            end
            prev_rdy = bus.mem_ready;
        end
        if (lat < 0) chk("retire_timeout", 0, 1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [31:0] c0;
        logic r5;
        int bad_il, bad_cnt;
        bit found;

        vecs[0] = '{"addi",  I_ADDI, 1'b0, 4, 1, 0, 1, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[1] = '{"add",   I_ADD,  1'b0, 4, 1, 0, 1, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[2] = '{"lbu",   I_LBU,  1'b0, 5, 1, 0, 2, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[3] = '{"sb",    I_SB,   1'b0, 4, 0, 1, 2, 1'b0, 1'b0, 2'b01, 1'b1};
        vecs[4] = '{"bne_t", I_BNE,  1'b0, 3, 0, 0, 1, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[5] = '{"bne_n", I_BNE,  1'b1, 3, 0, 0, 1, 1'b0, 1'b1, 2'b00, 1'b0};

        bus.run = 1'b0; bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
        model_cnt = '0; last_cnt = '0;

        // Reset state
        #1;
        chk("reset_outputs", outs(), 16'h0);
        chk("reset_count", bus.instr_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single instructions, mem_ready tied high
        foreach (vecs[i]) begin
            run_one(vecs[i].ins, vecs[i].zero, 1'b1, 0, 1'b1);
            chk({vecs[i].name, "_latency"},   lat,       vecs[i].lat);
            chk({vecs[i].name, "_reg_write"}, n_rw,      vecs[i].rw);
            chk({vecs[i].name, "_mem_we"},    n_we,      vecs[i].we);
            chk({vecs[i].name, "_mem_req"},   n_req,     vecs[i].req);
            chk({vecs[i].name, "_pc_write"},  pcw_last,  vecs[i].pcw);
            chk({vecs[i].name, "_pc_src"},    pcs_last,  vecs[i].pcs);
            chk({vecs[i].name, "_dec_imm"},   {imm2, src2}, {2'b10, 1'b1});
            chk({vecs[i].name, "_imm3"},      {imm3, src3}, {vecs[i].imm3, vecs[i].src3});
            chk({vecs[i].name, "_idle_after"}, after_req, 1'b0);
        end

        // LBU with mem_ready arriving on the third cycle of each request
        run_one(I_LBU, 1'b0, 1'b0, 2, 1'b1);
        chk("lbu_slow_latency", lat, 9);
        chk("lbu_slow_req_cycles", n_req, 6);
        chk("lbu_slow_req_hold", hold_bad, 1'b0);
        chk("lbu_slow_reg_write", {n_rw[7:0], rw_last}, {8'd1, 1'b1});

        // Back-to-back ADDI with run held high
        c0 = bus.instr_count;
        bus.instr = I_ADDI; bus.mem_ready = 1'b1; bus.run = 1'b1;
        model_cnt = model_cnt + 1; sb_q.push_back(model_cnt);
        model_cnt = model_cnt + 1; sb_q.push_back(model_cnt);
        r5 = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 5) r5 = bus.mem_req;
            if (cyc == 8) bus.run = 1'b0;
        end
        tick();
        chk("b2b_count", bus.instr_count, c0 + 32'd2);
        chk("b2b_refetch", r5, 1'b1);
        chk("b2b_idle", bus.mem_req, 1'b0);

        // Illegal instruction: sticky trap, frozen count, cleared by reset
        c0 = bus.instr_count;
        bus.instr = 32'h0; bus.mem_ready = 1'b1; bus.run = 1'b1;
        tick(); bus.run = 1'b0;
        tick();
        tick();
        chk("trap_enter", bus.illegal, 1'b1);
        bad_il = 0; bad_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.illegal !== 1'b1) bad_il++;
            if (bus.instr_count !== c0) bad_cnt++;
            if (outs() !== 16'h0001) bad_il++;
        end
        chk("trap_illegal_held", bad_il, 0);
        chk("trap_count_frozen", bad_cnt, 0);
        rst_n = 1'b0;
        last_cnt = '0; model_cnt = '0; sb_q.delete();
        #1;
        chk("trap_reset_illegal", bus.illegal, 1'b0);
        chk("trap_reset_count", bus.instr_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while a store is waiting for mem_ready
        bus.instr = I_SB; bus.mem_ready = 1'b1; bus.run = 1'b1;
        found = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cyc == 1) bus.run = 1'b0;
            if (bus.mem_we === 1'b1) begin
                found = 1;
                bus.mem_ready = 1'b0;
                break;
            end
        end
        chk("wr_reached", found, 1'b1);
        chk("wr_req_before_reset", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("wr_reset_req_drop", {bus.mem_req, bus.mem_we}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("wr_reset_idle", outs(), 16'h0);

        // Counter wrap on SB retire, run dropped during the instruction
        @(negedge clk);
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        chk("wrap_preload", bus.instr_count, 32'hFFFF_FFFF);
        last_cnt = 32'hFFFF_FFFF; model_cnt = 32'hFFFF_FFFF;
        run_one(I_SB, 1'b0, 1'b1, 0, 1'b1);
        chk("wrap_count", bus.instr_count, 32'h0);
        chk("wrap_latency", lat, 4);
        chk("wrap_idle_after", after_req, 1'b0);
        tick();
        chk("wrap_stays_idle", outs(), 16'h0);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
